// File: rtl/calc_pkg.sv
// Shared definitions for the accumulator-calculator command path.
// Contents:
//   OP_*      4-bit calculator opcodes, OP_NOP (0) through OP_NOT (15)
//   ERR_*     2-bit response error codes
//   state_t   command issuer FSM states
//   map_error converts the raw calculator error flags to a response code
//   is_halting true for the response codes that stop the command stream
package calc_pkg;

   localparam logic [3:0] OP_NOP     = 4'd0;
   localparam logic [3:0] OP_RESET   = 4'd1;
   localparam logic [3:0] OP_LOAD    = 4'd2;
   localparam logic [3:0] OP_ILLEGAL = 4'd3;
   localparam logic [3:0] OP_ADD     = 4'd4;
   localparam logic [3:0] OP_SUB     = 4'd5;
   localparam logic [3:0] OP_MUL     = 4'd6;
   localparam logic [3:0] OP_DIV     = 4'd7;
   localparam logic [3:0] OP_MOD     = 4'd8;
   localparam logic [3:0] OP_AND     = 4'd9;
   localparam logic [3:0] OP_OR      = 4'd10;
   localparam logic [3:0] OP_XOR     = 4'd11;
   localparam logic [3:0] OP_SHL     = 4'd12;
   localparam logic [3:0] OP_SHR     = 4'd13;
   localparam logic [3:0] OP_NEG     = 4'd14;
   localparam logic [3:0] OP_NOT     = 4'd15;

   localparam logic [1:0] ERR_OK       = 2'b00;
   localparam logic [1:0] ERR_OVERFLOW = 2'b01;
   localparam logic [1:0] ERR_DIV_ZERO = 2'b10;
   localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP,
      HALT
   } state_t;

   // Divide-by-zero wins if the calculator ever flags both bits at once,
   // so a raw 11 can never be mistaken for the illegal-opcode code.
   function automatic logic [1:0] map_error(input logic [1:0] calc_err);
      if (calc_err[1]) return ERR_DIV_ZERO;
      if (calc_err[0]) return ERR_OVERFLOW;
      return ERR_OK;
   endfunction

   function automatic logic is_halting(input logic [1:0] rsp_err);
      return (rsp_err == ERR_OVERFLOW) || (rsp_err == ERR_DIV_ZERO);
   endfunction

endpackage

// File: rtl/calc_cmd_fifo.sv
// Command FIFO for the calculator issuer.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   push, wdata  write request and entry; ignored while full
//   pop          read request; ignored while empty
//   rdata        head entry (registered storage, no write-to-read bypass)
//   full, empty  status flags decoded from the registered pointers
module calc_cmd_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // The extra top bit distinguishes full from empty when the indexes match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rdata   = mem[rd_ptr[AW-1:0]];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/calc_cmd_issuer.sv
// Drives queued (opcode, operand) commands onto the accumulator calculator
// one at a time and returns each result on a valid/ready response channel.
// Ports:
//   Clk, Rst_n                  clock and asynchronous active-low reset
//   CmdValid/CmdReady/CmdOp/CmdData   command input channel into the FIFO
//   OpCode, InputA              registered drive of the calculator inputs
//   Error, Result               calculator error flags and accumulator value
//   RspValid/RspReady/RspOp/RspData/RspErr   response channel
//   ClearHalt, Halted           leave / report the post-error halt
//   Busy                        state not IDLE or commands still queued
module calc_cmd_issuer
   import calc_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        CmdValid,
   output logic        CmdReady,
   input  logic [3:0]  CmdOp,
   input  logic [15:0] CmdData,
   output logic [3:0]  OpCode,
   output logic [15:0] InputA,
   input  logic [1:0]  Error,
   input  logic [31:0] Result,
   output logic        RspValid,
   input  logic        RspReady,
   output logic [3:0]  RspOp,
   output logic [31:0] RspData,
   output logic [1:0]  RspErr,
   input  logic        ClearHalt,
   output logic        Halted,
   output logic        Busy
);

   state_t      state;
   logic [1:0]  pend_err;
   logic        fifo_full;
   logic        fifo_empty;
   logic [19:0] head;
   logic [3:0]  head_op;
   logic [15:0] head_data;
   logic        rsp_hs;
   logic        pop;

   calc_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (20)
   ) u_fifo (
      .clk   (Clk),
      .rst_n (Rst_n),
      .push  (CmdValid),
      .wdata ({CmdOp, CmdData}),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign head_op   = head[19:16];
   assign head_data = head[15:0];
   assign CmdReady  = !fifo_full;
   assign Busy      = (state != IDLE) || !fifo_empty;
   assign rsp_hs    = RspValid && RspReady;

   // A new command is taken from IDLE, or straight out of RESP when the
   // answered command did not trip a halt, which gives one command per 3 cycles.
   assign pop = !fifo_empty &&
                ((state == IDLE) || ((state == RESP) && rsp_hs && !is_halting(RspErr)));

   // The state transitions come first; the pop handling at the bottom then
   // overrides the destination whenever a command is taken from the FIFO.
   // Illegal opcodes are answered immediately and never reach OpCode.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state    <= IDLE;
         OpCode   <= OP_NOP;
         InputA   <= '0;
         pend_err <= ERR_OK;
         RspValid <= 1'b0;
         RspOp    <= '0;
         RspData  <= '0;
         RspErr   <= ERR_OK;
         Halted   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               OpCode <= OP_NOP;
            end
            ISSUE: begin
               pend_err <= map_error(Error);
               OpCode   <= OP_NOP;
               InputA   <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               RspData  <= Result;
               RspErr   <= pend_err;
               RspValid <= 1'b1;
               state    <= RESP;
            end
            RESP: begin
               if (rsp_hs) begin
                  RspValid <= 1'b0;
                  if (is_halting(RspErr)) begin
                     state  <= HALT;
                     Halted <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            HALT: begin
               OpCode <= OP_NOP;
               if (ClearHalt) begin
                  Halted <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase

         if (pop) begin
            RspOp <= head_op;
            if (head_op == OP_ILLEGAL) begin
               RspValid <= 1'b1;
               RspErr   <= ERR_ILLEGAL;
               RspData  <= Result;
               state    <= RESP;
            end else begin
               OpCode <= head_op;
               InputA <= head_data;
               state  <= ISSUE;
            end
         end
      end
   end

endmodule

// File: tb/tb_calc_cmd_issuer.sv
// Self-checking bench for calc_cmd_issuer. A small accumulator calculator
// model sits on the OpCode/InputA side; expected responses are derived from
// each accepted command applied in order to a reference accumulator.
module tb_calc_cmd_issuer;

   localparam logic [3:0] C_RESET = 4'd1, C_LOAD = 4'd2, C_ILL = 4'd3, C_ADD = 4'd4,
                          C_SUB = 4'd5, C_MUL = 4'd6, C_DIV = 4'd7, C_MOD = 4'd8,
                          C_AND = 4'd9, C_OR = 4'd10, C_XOR = 4'd11, C_NOT = 4'd15;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] data;
      logic [1:0]  err;
   } rsp_t;

   logic        Clk = 1'b0;
   logic        Rst_n = 1'b1;
   logic        CmdValid = 1'b0;
   logic        CmdReady;
   logic [3:0]  CmdOp = '0;
   logic [15:0] CmdData = '0;
   logic [3:0]  OpCode;
   logic [15:0] InputA;
   logic [1:0]  Error;
   logic [31:0] Result;
   logic        RspValid;
   logic        RspReady = 1'b0;
   logic [3:0]  RspOp;
   logic [31:0] RspData;
   logic [1:0]  RspErr;
   logic        ClearHalt = 1'b0;
   logic        Halted;
   logic        Busy;

   int testCount = 0;
   int failCount = 0;

   calc_cmd_issuer #(.DEPTH(8)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .CmdValid(CmdValid), .CmdReady(CmdReady),
      .CmdOp(CmdOp), .CmdData(CmdData), .OpCode(OpCode), .InputA(InputA),
      .Error(Error), .Result(Result), .RspValid(RspValid), .RspReady(RspReady),
      .RspOp(RspOp), .RspData(RspData), .RspErr(RspErr), .ClearHalt(ClearHalt),
      .Halted(Halted), .Busy(Busy)
   );

   always #5 Clk = ~Clk;

   // Calculator behaviour: returns {error flags, next accumulator}. Add/sub
   // flag overflow outside the signed 16-bit range; divide and modulus take
   // the accumulator as divisor. An erroring operation leaves the value alone.
   function automatic logic [33:0] calcStep(input logic [31:0] acc, input logic [3:0] op,
                                            input logic [15:0] a);
      longint sacc;
      longint sa;
      longint r;
      logic [31:0] n;
      logic [1:0]  e;
      sacc = longint'($signed(acc));
      sa   = longint'($signed(a));
      n    = acc;
      e    = 2'b00;
      case (op)
         C_RESET: n = 32'd0;
         C_LOAD:  n = 32'(sa);
         C_ADD, C_SUB: begin
            r = (op == C_ADD) ? sacc + sa : sacc - sa;
            if (r > 32767 || r < -32768) e = 2'b01;
            else n = 32'(r);
         end
         C_MUL: n = 32'(sacc * sa);
         C_DIV, C_MOD: begin
            if (sacc == 0) e = 2'b10;
            else n = 32'((op == C_DIV) ? sa / sacc : sa % sacc);
         end
         C_AND: n = acc & {16'h0, a};
         C_OR:  n = acc | {16'h0, a};
         C_XOR: n = acc ^ {16'h0, a};
         C_NOT: n = ~acc;
         default: n = acc;
      endcase
      return {e, n};
   endfunction

   // Calculator instance: never reset by the issuer.
   logic [31:0] calcAcc = '0;
   logic [33:0] calcNext;
   always_comb calcNext = calcStep(calcAcc, OpCode, InputA);
   assign Error  = calcNext[33:32];
   assign Result = calcAcc;
   always @(posedge Clk) calcAcc <= calcNext[31:0];

   // Bench state shared by the stimulus tasks.
   logic [19:0] pendQ[$];
   rsp_t        expQ[$];
   logic [31:0] modelAcc = '0;
   int          rspMode = 1;
   bit          randomGaps = 0;
   bit          clearReq = 0;
   bit          haltSeen = 0;
   bit          prevValid = 0;
   bit          checkLatency = 0;
   int          latAccept = -1;
   int          haltCnt = 0;
   int          cycle = 0;
   int          acceptCount = 0;
   int          rspCount = 0;
   rsp_t        lastRsp;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      testCount++;
      assert (obs === expv) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] op, input logic [15:0] data);
      pendQ.push_back({op, data});
   endtask

   // Reference model: each accepted command produces its response up front.
   task automatic modelAccept(input logic [3:0] op, input logic [15:0] data);
      rsp_t r;
      logic [33:0] s;
      r.op = op;
      if (op == C_ILL) begin
         r.data = modelAcc;
         r.err  = 2'b11;
      end else begin
         s = calcStep(modelAcc, op, data);
         modelAcc = s[31:0];
         r.data = s[31:0];
         r.err  = s[33:32];
      end
      expQ.push_back(r);
   endtask

   task automatic stepCycle();
      bit   accOk;
      bit   hs;
      rsp_t got;
      rsp_t want;
      @(negedge Clk);
      if (pendQ.size() > 0 && (!randomGaps || $urandom_range(0, 2) != 0)) begin
         CmdValid = 1'b1;
         CmdOp    = pendQ[0][19:16];
         CmdData  = pendQ[0][15:0];
      end else begin
         CmdValid = 1'b0;
         CmdOp    = '0;
         CmdData  = '0;
      end
      RspReady  = (rspMode == 2) ? 1'($urandom_range(0, 1)) : (rspMode == 1);
      ClearHalt = clearReq || (randomGaps && !Halted && $urandom_range(0, 7) == 0);
      clearReq  = 0;
      #1;
      accOk  = CmdValid && CmdReady;
      hs     = RspValid && RspReady;
      got.op = RspOp; got.data = RspData; got.err = RspErr;
      checkOutput("opcode_never_illegal", 32'(OpCode == C_ILL), 32'd0);
      if (Halted) checkOutput("halt_opcode_nop", 32'(OpCode), 32'd0);
      @(posedge Clk);
      cycle++;
      #1;
      if (accOk) begin
         modelAccept(pendQ[0][19:16], pendQ[0][15:0]);
         void'(pendQ.pop_front());
         acceptCount++;
         if (checkLatency && latAccept < 0) latAccept = cycle;
      end
      if (hs) begin
         rspCount++;
         lastRsp = got;
         if (expQ.size() == 0) begin
            checkOutput("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            want = expQ.pop_front();
            checkOutput("rsp_op", 32'(got.op), 32'(want.op));
            checkOutput("rsp_data", got.data, want.data);
            checkOutput("rsp_err", 32'(got.err), 32'(want.err));
            checkOutput("halted_after_rsp", 32'(Halted),
                        32'(want.err == 2'b01 || want.err == 2'b10));
         end
      end
      if (checkLatency && latAccept >= 0 && RspValid && !prevValid) begin
         checkOutput("first_rsp_latency", 32'(cycle - latAccept), 32'd3);
         checkLatency = 0;
      end
      prevValid = RspValid;
      if (Halted) begin
         haltSeen = 1;
         haltCnt++;
         if (haltCnt >= 3) begin
            clearReq = 1;
            haltCnt  = 0;
         end
      end else begin
         haltCnt = 0;
      end
   endtask

   task automatic drainAll(input int maxCycles);
      for (int i = 0; i < maxCycles && (pendQ.size() != 0 || expQ.size() != 0 || Halted); i++)
         stepCycle();
      checkOutput("drain_complete", {30'd0, pendQ.size() == 0, expQ.size() == 0}, 32'd3);
      checkOutput("drain_not_halted", 32'(Halted), 32'd0);
   endtask

   task automatic resetAndCheck();
      Rst_n = 1'b0;
      CmdValid = 1'b0; RspReady = 1'b0; ClearHalt = 1'b0;
      #1;
      checkOutput("rst_opcode", 32'(OpCode), 32'd0);
      checkOutput("rst_inputa", 32'(InputA), 32'd0);
      checkOutput("rst_rspvalid", 32'(RspValid), 32'd0);
      checkOutput("rst_rspop", 32'(RspOp), 32'd0);
      checkOutput("rst_rspdata", RspData, 32'd0);
      checkOutput("rst_rsperr", 32'(RspErr), 32'd0);
      checkOutput("rst_halted", 32'(Halted), 32'd0);
      checkOutput("rst_busy", 32'(Busy), 32'd0);
      repeat (2) @(negedge Clk);
      Rst_n = 1'b1;
      #1;
      checkOutput("rst_cmdready", 32'(CmdReady), 32'd1);
      pendQ.delete();
      expQ.delete();
      prevValid = 0;
      haltCnt = 0;
      clearReq = 0;
   endtask

   initial begin
      int baseRsp;
      logic [3:0] opList [12];
      opList = '{C_RESET, C_LOAD, C_ADD, C_SUB, C_MUL, C_DIV, C_MOD,
                 C_AND, C_OR, C_XOR, C_NOT, C_ILL};
      #2;
      resetAndCheck();

      // Basic sequence plus multiply, with first-response latency.
      rspMode = 1;
      checkLatency = 1;
      applyStimulus(C_RESET, 16'd0);
      applyStimulus(C_ADD, 16'd250);
      applyStimulus(C_MUL, 16'd150);
      drainAll(100);
      checkOutput("mul_result", lastRsp.data, 32'h0000927C);
      checkOutput("mul_err", 32'(lastRsp.err), 32'd0);
      checkOutput("latency_measured", 32'(checkLatency), 32'd0);

      // Overflow halt; ADD 5 waits until the halt is cleared.
      haltSeen = 0;
      applyStimulus(C_RESET, 16'd0);
      applyStimulus(C_ADD, 16'd1);
      applyStimulus(C_ADD, 16'h7FFF);
      applyStimulus(C_ADD, 16'd5);
      drainAll(200);
      checkOutput("ovf_halt_seen", 32'(haltSeen), 32'd1);
      checkOutput("ovf_add5_result", lastRsp.data, 32'd6);

      // Divide by zero halts.
      haltSeen = 0;
      applyStimulus(C_RESET, 16'd0);
      applyStimulus(C_DIV, 16'd5);
      drainAll(100);
      checkOutput("div0_halt_seen", 32'(haltSeen), 32'd1);
      checkOutput("div0_err", 32'(lastRsp.err), 32'd2);

      // Illegal opcode: answered without halting or driving OpCode.
      haltSeen = 0;
      applyStimulus(C_LOAD, 16'h1234);
      applyStimulus(C_ILL, 16'd99);
      applyStimulus(C_ADD, 16'd1);
      drainAll(100);
      checkOutput("ill_no_halt", 32'(haltSeen), 32'd0);
      checkOutput("ill_last_data", lastRsp.data, 32'h1235);

      // Backpressure from reset: 1 held in RESP plus 8 queued.
      resetAndCheck();
      rspMode = 0;
      acceptCount = 0;
      applyStimulus(C_RESET, 16'd0);
      for (int i = 0; i < 11; i++) applyStimulus(C_ADD, 16'($urandom_range(0, 200)));
      repeat (25) stepCycle();
      checkOutput("bp_accepts", 32'(acceptCount), 32'd9);
      checkOutput("bp_cmdready", 32'(CmdReady), 32'd0);
      checkOutput("bp_busy", 32'(Busy), 32'd1);
      rspMode = 1;
      drainAll(200);

      // Randomized commands, gaps, response stalls and stray ClearHalt pulses.
      rspMode = 2;
      randomGaps = 1;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) applyStimulus(opList[$urandom_range(0, 11)], 16'd0);
         else applyStimulus(opList[$urandom_range(0, 11)], 16'($urandom));
      end
      drainAll(3000);
      randomGaps = 0;

      // Reset while the command is in WAIT: dropped with no response.
      rspMode = 1;
      applyStimulus(C_ADD, 16'd7);
      repeat (3) stepCycle();
      checkOutput("pre_reset_no_valid", 32'(RspValid), 32'd0);
      resetAndCheck();
      baseRsp = rspCount;
      repeat (6) stepCycle();
      checkOutput("no_rsp_after_reset", 32'(rspCount - baseRsp), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
